// File: rtl/cci_mpf_prim_pkg.sv
// Shared constants and types for the MPF primitive library.
package cci_mpf_prim_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] skid_count_t;

  localparam skid_count_t SKID_EMPTY = 2'd0;
  localparam skid_count_t SKID_ONE   = 2'd1;
  localparam skid_count_t SKID_FULL  = 2'd2;

endpackage : cci_mpf_prim_pkg

// File: rtl/cci_mpf_prim_skid_fifo2.sv
// Generic 2-entry valid/ready queue; the head entry is held in a register
// that drives out_data directly.
module cci_mpf_prim_skid_fifo2
  import cci_mpf_prim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  skid_count_t           count_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic                  out_valid_r;
  logic                  push_s;
  logic                  pop_s;

  // Readiness depends only on occupancy, never on out_ready.
  assign in_ready  = (count_r != SKID_FULL) && !reset;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid_r && out_ready;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

  // Occupancy and storage update; push+pop only reaches here at count 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= SKID_EMPTY;
      head_r      <= {DATA_WIDTH{1'b0}};
      tail_r      <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == SKID_EMPTY) begin
            head_r <= in_data;
          end else begin
            tail_r <= in_data;
          end
          count_r     <= count_r + 2'd1;
          out_valid_r <= 1'b1;
        end
        2'b01: begin
          head_r      <= tail_r;
          count_r     <= count_r - 2'd1;
          out_valid_r <= (count_r == SKID_FULL);
        end
        2'b11: begin
          head_r <= in_data;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule : cci_mpf_prim_skid_fifo2

// File: rtl/cci_mpf_prim_bin_to_onehot_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid queue.
// Optional range checking: define CCI_MPF_PRIM_BIN_TO_ONEHOT_RANGE_CHECK_EN.
module cci_mpf_prim_bin_to_onehot_pipe
  import cci_mpf_prim_pkg::*;
#(
  parameter int unsigned ONEHOT_WIDTH = 16,
  parameter int unsigned BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ONEHOT_WIDTH-1:0] out_onehot,
  output logic                    out_range_err,
  output logic                    err_sticky
);

`ifdef CCI_MPF_PRIM_BIN_TO_ONEHOT_RANGE_CHECK_EN
  localparam int unsigned FIFO_WIDTH = ONEHOT_WIDTH + 1;
`else
  localparam int unsigned FIFO_WIDTH = ONEHOT_WIDTH;
`endif

  logic [ONEHOT_WIDTH-1:0] onehot_s;
  logic [FIFO_WIDTH-1:0]   fifo_in_s;
  logic [FIFO_WIDTH-1:0]   fifo_out_s;

  // Out-of-range indices match no bit and decode to all zeros.
  always_comb begin
    onehot_s = {ONEHOT_WIDTH{1'b0}};
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      onehot_s[i] = (32'(in_bin) == i);
    end
  end

`ifdef CCI_MPF_PRIM_BIN_TO_ONEHOT_RANGE_CHECK_EN
  logic range_err_s;
  logic err_sticky_r;

  assign range_err_s   = (32'(in_bin) >= ONEHOT_WIDTH);
  assign fifo_in_s     = {range_err_s, onehot_s};
  assign out_onehot    = fifo_out_s[ONEHOT_WIDTH-1:0];
  assign out_range_err = fifo_out_s[ONEHOT_WIDTH];
  assign err_sticky    = err_sticky_r;

  // Sticky error sets when a bad index is pushed and clears only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_r <= 1'b0;
    end else if (in_valid && in_ready && range_err_s) begin
      err_sticky_r <= 1'b1;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end
`else
  assign fifo_in_s     = onehot_s;
  assign out_onehot    = fifo_out_s;
  assign out_range_err = 1'b0;
  assign err_sticky    = 1'b0;
`endif

  cci_mpf_prim_skid_fifo2 #(
    .DATA_WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (fifo_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out_s)
  );

endmodule : cci_mpf_prim_bin_to_onehot_pipe

// File: doc/cci_mpf_prim_bin_to_onehot_pipe.md
# cci_mpf_prim_bin_to_onehot_pipe

A registered, flow-controlled binary-to-one-hot decoder. It accepts a binary index on a valid/ready input, expands the index to a one-hot vector, and buffers the result in a 2-entry skid queue behind a valid/ready output. It sits where MPF logic turns an allocated slot or channel index back into a per-slot select mask. Examples are ROB slot release and per-VC grant vectors. It is the mirror of the one-hot-to-binary primitive.

## Interface
Parameters:
- ONEHOT_WIDTH, 16: number of one-hot output bits. Any value ≥ 2 is allowed, including values that are not a power of 2.
- BIN_WIDTH, $clog2(ONEHOT_WIDTH): width of the binary index.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept an input beat.
- in_bin  in  BIN_WIDTH  binary index.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the output beat.
- out_onehot  out  ONEHOT_WIDTH  decoded mask.
- out_range_err  out  1  the current output beat came from an out-of-range index.
- err_sticky  out  1  an out-of-range index has been seen since reset.

## Operation
- Input transfer: occurs on a clk edge where in_valid && in_ready.
- Output transfer: occurs on a clk edge where out_valid && out_ready.
- Decode rule:
  - out_onehot[i] = (in_bin == i) for i in 0..ONEHOT_WIDTH-1.
  - The decode is computed at the input and stored into the queue.
  - Decoded data, not the binary index, is held in the queue.
- Queue behaviour:
  - 2-entry FIFO with occupancy count 0..2.
  - The output always presents the head entry.
  - in_ready = (count < 2) && !reset. It never depends combinationally on out_ready.
- Count update on each edge:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together at count 1: count stays 1. The new entry becomes head on the following cycle.
  - Push and pop together at count 2: cannot occur, because in_ready=0.
- Out-of-range index (in_bin ≥ ONEHOT_WIDTH; possible only when ONEHOT_WIDTH is not a power of 2):
  - out_onehot is all zeros for that beat.
  - For flag behaviour, see Configuration.
- Ordering: beats leave in arrival order. Nothing is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_onehot and out_range_err hold constant.

## Timing
- Reset values:
  - out_valid=0, count=0, out_onehot=0, out_range_err=0, err_sticky=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset deasserts.
- Reset mid-operation: all queued beats are discarded. No output beat appears on the cycle after reset.
- Latency: an input accepted on edge N gives out_valid=1 after edge N, if count was 0.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two beats are accepted, then in_ready drops on the cycle after the second accept.
- Recovery: in_ready returns to 1 on the cycle after the first pop.
- Registered outputs: all outputs are registered except in_ready, which is derived from the count register and reset.

## Configuration
- Macro: CCI_MPF_PRIM_BIN_TO_ONEHOT_RANGE_CHECK_EN.
- Defined:
  - The range comparison is built.
  - The queue carries 1 extra error bit per entry.
  - out_range_err is asserted with an out-of-range beat.
  - err_sticky sets on the edge where that beat is pushed, and holds until reset.
- Undefined:
  - The comparator and error bit are removed.
  - out_range_err and err_sticky are tied 0.
  - Out-of-range beats still produce an all-zero mask.

## Structure
- Shared package cci_mpf_prim_pkg: the queue depth constant (2) and the occupancy count typedef.
- Sub-module cci_mpf_prim_skid_fifo2: a generic 2-entry valid/ready queue parameterized by data width.
  - This block instantiates it with width ONEHOT_WIDTH, or ONEHOT_WIDTH+1 with range check enabled.
  - This block owns only the decode and the sticky flag.

## Test plan
- Sweep (ONEHOT_WIDTH=16): push in_bin 0..15 with out_ready=1 → one beat per cycle, out_onehot=16'h0001<<k in order, latency 1.
- Backpressure: out_ready=0, push 3, 7, 9 → 3 and 7 accepted; in_ready=0 while 9 is held. out_ready=1 → 16'h0008, 16'h0080, 16'h0200 in order, with no gaps after release.
- Out of range (ONEHOT_WIDTH=12, macro on): push in_bin 13 → out_onehot=12'h000, out_range_err=1, err_sticky=1. Then push 2 → 12'h004, out_range_err=0, err_sticky stays 1.
- Macro off, same stimulus → mask 12'h000, out_range_err=0, err_sticky=0.
- Simultaneous push/pop at count 1 (out_ready=1, continuous input 5, 6) → count stays 1, outputs 16'h0020 then 16'h0040.
- Reset with 2 entries queued → out_valid=0 and in_ready=0 during reset. Next push 4 → first output 16'h0010 with no stale data.
